// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar trigger/echo sensor emulator and its
// controller: responder state encoding, clock rate and range-grid boundaries.
package sonar_pkg;

   // Responder protocol states.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG_HIGH = 3'd1,
      BURST     = 3'd2,
      ECHO_HIGH = 3'd3,
      HOLDOFF   = 3'd4
   } responder_state_t;

   localparam int unsigned CLK_HZ            = 100_000_000;
   localparam int unsigned CYCLES_PER_MM_DEF = 583;

   // Width of the state counter and of the latched echo width.
   localparam int unsigned CNT_W  = 24;
   // Width of the emulated distance input.
   localparam int unsigned DIST_W = 12;

   // Echo-width boundaries between controller range grid cells.
   localparam logic [CNT_W-1:0] GRID_B0 = 24'd252300;
   localparam logic [CNT_W-1:0] GRID_B1 = 24'd519100;
   localparam logic [CNT_W-1:0] GRID_B2 = 24'd758640;
   localparam logic [CNT_W-1:0] GRID_B3 = 24'd979040;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic sync_p0;
   logic sync_p1;

   // Two back-to-back flops give the first one a full cycle to resolve metastability.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= d;
         sync_p1 <= sync_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/sonar_echo_responder.sv
// Ultrasonic range-sensor emulator: answers a trigger pulse with an echo pulse
// whose width encodes a programmable distance, then holds off before re-arming.
module sonar_echo_responder
   import sonar_pkg::*;
#(
   parameter int unsigned MIN_TRIG_CYCLES = 1000,
   parameter int unsigned BURST_CYCLES    = 20000,
   parameter int unsigned CYCLES_PER_MM   = CYCLES_PER_MM_DEF,
   parameter int unsigned MAX_MM          = 4000,
   parameter int unsigned NO_OBJ_CYCLES   = 3_800_000,
   parameter int unsigned HOLDOFF_CYCLES  = 6_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              trigger,
   input  logic [DIST_W-1:0] distance_mm,
   input  logic              object_present,
   output logic              echo,
   output logic              busy,
   output logic              trig_err
);

   // Terminal counts are held at counter width so every compare is width-matched.
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  MIN_LAST   = CNT_W'(MIN_TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_CYCLES - 1);
   localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0]  NO_OBJ_W   = CNT_W'(NO_OBJ_CYCLES);
   localparam logic [CNT_W-1:0]  CPM_W      = CNT_W'(CYCLES_PER_MM);
   localparam logic [DIST_W-1:0] MAX_MM_W   = DIST_W'(MAX_MM);

   responder_state_t state;
   responder_state_t state_nxt;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] width;
   logic [CNT_W-1:0] width_last;

   logic trig_s;
   logic trig_d;
   logic trig_rise;
   logic trig_fall;
   logic trig_ok;
   logic latch_en;
   logic echo_nxt;
   logic trig_err_nxt;

   // Echo width for a given distance. A 12-bit distance times a 10-bit
   // cycles-per-mm factor always fits in the 24-bit result.
   function automatic logic [CNT_W-1:0] calc_width(input logic [DIST_W-1:0] mm,
                                                   input logic present);
      logic [CNT_W-1:0] prod;
      prod = CNT_W'(mm) * CPM_W;
      if (!present || (mm > MAX_MM_W))
         return NO_OBJ_W;
      else if (mm == '0)
         return CNT_W'(1);
      else
         return prod;
   endfunction

   sync_2ff u_trig_sync (
      .clk   (clk),
      .reset (reset),
      .d     (trigger),
      .q     (trig_s)
   );

   // One-cycle delayed copy of the synchronized trigger for edge detection.
   always_ff @(posedge clk) begin
      if (reset)
         trig_d <= 1'b0;
      else
         trig_d <= trig_s;
   end

   assign trig_rise  = trig_s & ~trig_d;
   assign trig_fall  = ~trig_s & trig_d;
   // cnt misses the cycle in which the rise was detected, so one fewer
   // counted cycle already means MIN_TRIG_CYCLES of synchronized high time.
   assign trig_ok    = (cnt >= MIN_LAST);
   assign latch_en   = (state == TRIG_HIGH) && trig_fall && trig_ok;
   assign width_last = width - CNT_W'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode; trigger edges outside IDLE/TRIG_HIGH are never looked at.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (trig_rise)
               state_nxt = TRIG_HIGH;
         end
         TRIG_HIGH: begin
            if (trig_fall)
               state_nxt = trig_ok ? BURST : IDLE;
         end
         BURST: begin
            if (cnt == BURST_LAST)
               state_nxt = ECHO_HIGH;
         end
         ECHO_HIGH: begin
            if (cnt == width_last)
               state_nxt = HOLDOFF;
         end
         HOLDOFF: begin
            if (cnt == HOLD_LAST)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Counter update: cleared on every state change, saturating while the trigger is held.
   always_comb begin
      cnt_nxt = cnt;
      if (state_nxt != state) begin
         cnt_nxt = '0;
      end else begin
         case (state)
            TRIG_HIGH: begin
               if (trig_s && (cnt != CNT_MAX))
                  cnt_nxt = cnt + CNT_W'(1);
            end
            BURST, ECHO_HIGH, HOLDOFF: cnt_nxt = cnt + CNT_W'(1);
            default: cnt_nxt = '0;
         endcase
      end
   end

   // Output decode; echo and trig_err are registered below, busy follows state.
   always_comb begin
      busy         = (state == BURST) || (state == ECHO_HIGH) || (state == HOLDOFF);
      echo_nxt     = (state == ECHO_HIGH);
      trig_err_nxt = (state == TRIG_HIGH) && trig_fall && !trig_ok;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

   // Echo width captured at an accepted trigger fall; later input changes cannot disturb it.
   always_ff @(posedge clk) begin
      if (latch_en)
         width <= calc_width(distance_mm, object_present);
   end

   // Registered pin outputs so the controller sees glitch-free levels.
   always_ff @(posedge clk) begin
      if (reset) begin
         echo     <= 1'b0;
         trig_err <= 1'b0;
      end else begin
         echo     <= echo_nxt;
         trig_err <= trig_err_nxt;
      end
   end

endmodule
